// File: rtl/prime_scan.sv
// prime_scan: tick-driven prime counter with trial division.
//
// Each accepted rising edge of `tick` either tests the current candidate
// (STEP, mode=0) or walks forward until a prime is found (SEEK, mode=1).
// Primality is decided by trial division with d = 2, 3, ... while d*d <= n.
// Each remainder comes from a W-cycle restoring shift-subtract divider.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   tick           slow level strobe; only its rising edge is used
//   mode           0 = STEP, 1 = SEEK (captured when a tick is accepted)
//   limit          last candidate allowed (captured when a tick is accepted)
//   cnt            number of primes found, saturating
//   last_prime     most recent prime found (0 until the first one)
//   busy           high while a test is in progress
//   done           sticky: candidate range exhausted
//   sat            sticky: cnt has saturated
//   tick_lost      sticky: a tick edge arrived while busy and was dropped
module prime_scan #(
  parameter int W  = 20,
  parameter int CW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          mode,
  input  logic [W-1:0]  limit,
  output logic [CW-1:0] cnt,
  output logic [W-1:0]  last_prime,
  output logic          busy,
  output logic          done,
  output logic          sat,
  output logic          tick_lost
);

  localparam int BW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIV,
    S_EVAL,
    S_FINISH
  } state_t;

  state_t state, state_nx;

  logic          tick_q;
  logic [W-1:0]  n;         // candidate under test
  logic [W-1:0]  d;         // current trial divisor
  logic [W+1:0]  sq;        // d*d, kept incrementally
  logic [W-1:0]  r;         // partial remainder
  logic [W-1:0]  q;         // dividend shift register (MSB first)
  logic [BW-1:0] bcnt;      // divider bit counter
  logic          is_prime;  // result of the most recent CHECK
  logic          mode_r;
  logic [W-1:0]  lim_r;

  logic          edge_det;
  logic          sq_gt_n;
  logic          div_last;
  logic          n_max;
  logic          past_lim;
  logic [W:0]    r_sh;
  logic          r_ge;
  logic [W-1:0]  r_sub;

  assign edge_det = tick & ~tick_q;
  assign sq_gt_n  = sq > {2'b00, n};
  assign div_last = bcnt == BW'(W - 1);
  assign n_max    = &n;
  // Only meaningful when n is not all-ones, which is checked first.
  assign past_lim = (n + 1'b1) > lim_r;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder stays below d, so the difference always fits in W bits.
  assign r_sh  = {r, q[W-1]};
  assign r_ge  = r_sh >= {1'b0, d};
  assign r_sub = r_sh[W-1:0] - d;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (edge_det && !done && n <= limit) state_nx = S_CHECK;
      S_CHECK:  state_nx = sq_gt_n ? S_FINISH : S_DIV;
      S_DIV:    if (div_last) state_nx = S_EVAL;
      S_EVAL:   state_nx = (r == '0) ? S_FINISH : S_CHECK;
      S_FINISH: begin
        if (n_max || past_lim)       state_nx = S_IDLE;
        else if (!mode_r || is_prime) state_nx = S_IDLE;
        else                          state_nx = S_CHECK;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q     <= 1'b0;
      n          <= W'(2);
      d          <= W'(2);
      sq         <= (W+2)'(4);
      r          <= '0;
      q          <= '0;
      bcnt       <= '0;
      is_prime   <= 1'b0;
      mode_r     <= 1'b0;
      lim_r      <= '0;
      cnt        <= '0;
      last_prime <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sat        <= 1'b0;
      tick_lost  <= 1'b0;
    end else begin
      tick_q <= tick;
      // Registered copy of "not IDLE" so it lines up with the state register.
      busy   <= state_nx != S_IDLE;
      if (edge_det && state != S_IDLE) tick_lost <= 1'b1;

      case (state)
        S_IDLE: begin
          if (edge_det && !done) begin
            if (n > limit) begin
              done <= 1'b1;
            end else begin
              d      <= W'(2);
              sq     <= (W+2)'(4);
              mode_r <= mode;
              lim_r  <= limit;
            end
          end
        end
        S_CHECK: begin
          is_prime <= sq_gt_n;
          r        <= '0;
          q        <= n;
          bcnt     <= '0;
        end
        S_DIV: begin
          r    <= r_ge ? r_sub : r_sh[W-1:0];
          q    <= q << 1;
          bcnt <= bcnt + 1'b1;
        end
        S_EVAL: begin
          if (r != '0) begin
            // (d+1)^2 = d^2 + 2d + 1
            sq <= sq + {1'b0, d, 1'b1};
            d  <= d + 1'b1;
          end
        end
        S_FINISH: begin
          if (is_prime) begin
            last_prime <= n;
            if (&cnt) sat <= 1'b1;
            else      cnt <= cnt + 1'b1;
          end
          if (n_max || past_lim) begin
            done <= 1'b1;
          end else begin
            n  <= n + 1'b1;
            // Reload for a SEEK continuation; harmless when returning to IDLE.
            d  <= W'(2);
            sq <= (W+2)'(4);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_scan.sv
module tb_prime_scan;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst, tick, mode;
  logic [7:0] limit;

  logic [7:0] cnt0, last0;
  logic [2:0] cnt1;
  logic [7:0] last1;
  logic       busy0, done0, sat0, lost0;
  logic       busy1, done1, sat1, lost1;

  prime_scan #(.W(W), .CW(8)) u0 (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .limit(limit),
    .cnt(cnt0), .last_prime(last0), .busy(busy0), .done(done0),
    .sat(sat0), .tick_lost(lost0)
  );

  prime_scan #(.W(W), .CW(3)) u1 (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .limit(limit),
    .cnt(cnt1), .last_prime(last1), .busy(busy1), .done(done1),
    .sat(sat1), .tick_lost(lost1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int cnt8;
    int cnt3;
    bit sat8;
    bit sat3;
    int last;
    bit done;
    bit lost;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   flush    = 1'b0;
  bit   prev_busy = 1'b0;

  // Reference model: candidate, total primes (unsaturated), flags.
  int mn, mcount, mlast;
  bit mdone, mlost;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Trial division as the math defines it: number of divisors tried and
  // whether v is prime.
  function automatic void rounds_of(input int v, output int k, output bit p);
    k = 0;
    p = 1'b1;
    for (int dd = 2; dd * dd <= v; dd++) begin
      k++;
      if (v % dd == 0) begin
        p = 1'b0;
        return;
      end
    end
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    mn = 2; mcount = 0; mlast = 0; mdone = 1'b0; mlost = 1'b0;
  endtask

  // Apply one accepted-or-not edge to the model; push the expected
  // response when a test actually runs.
  task automatic model_edge(input bit md, input int lim, input int ecyc,
                            output bit starts);
    int   lat, k;
    bit   p;
    exp_t e;
    starts = 1'b0;
    if (mdone) return;
    if (mn > lim) begin
      mdone = 1'b1;
      return;
    end
    starts = 1'b1;
    lat = 1;
    forever begin
      rounds_of(mn, k, p);
      if (p) begin
        mcount++;
        mlast = mn;
      end
      lat += k * (W + 2) + (p ? 2 : 1);
      if (mn == 255 || mn + 1 > lim) begin
        mdone = 1'b1;
        break;
      end
      mn++;
      if (!md || p) break;
    end
    e.at   = ecyc + lat;
    e.cnt8 = min_i(mcount, 255);
    e.sat8 = mcount > 255;
    e.cnt3 = min_i(mcount, 7);
    e.sat3 = mcount > 7;
    e.last = mlast;
    e.done = mdone;
    e.lost = mlost;
    sbq.push_back(e);
  endtask

  // Monitor: every falling edge of busy is one completed test.
  always @(negedge clk) begin
    if (prev_busy && !busy0 && !flush) begin
      if (sbq.size() == 0) begin
        check("spurious_busy_fall", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("latency_cycle", cyc, e.at);
        check("busy_cw3", busy1, 0);
        check("cnt_cw8", cnt0, e.cnt8);
        check("cnt_cw3", cnt1, e.cnt3);
        check("sat_cw8", sat0, e.sat8);
        check("sat_cw3", sat1, e.sat3);
        check("last_prime", last0, e.last);
        check("last_prime_cw3", last1, e.last);
        check("done", done0, e.done);
        check("tick_lost", lost0, e.lost);
      end
    end
    prev_busy <= busy0;
  end

  task automatic do_reset();
    @(negedge clk);
    flush = 1'b1;
    tick  = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_cnt", cnt0, 0);
    check("rst_last", last0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_sat", sat0 | sat1, 0);
    check("rst_lost", lost0, 0);
    check("rst_cnt_cw3", cnt1, 0);
    sbq.delete();
    model_reset();
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Issue one tick edge; optionally a second edge two cycles later.
  task automatic do_edge(input bit md, input int lim, input bit dbl);
    bit starts;
    @(negedge clk);
    mode  = md;
    limit = 8'(lim);
    tick  = 1'b1;
    if (dbl && !mdone && mn <= lim) mlost = 1'b1;
    model_edge(md, lim, cyc, starts);
    @(negedge clk);
    tick = 1'b0;
    if (dbl) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    // Scramble inputs while busy: they must have been captured already.
    mode  = 1'($urandom_range(1, 0));
    limit = 8'($urandom_range(255, 0));
    if (starts) begin
      for (int i = 0; i < 3000 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
        check("response_timeout", sbq.size(), 0);
        sbq.delete();
      end
    end else begin
      repeat (3) @(negedge clk);
      check("idle_busy", busy0, 0);
      check("idle_done", done0, mdone);
      check("idle_cnt", cnt0, min_i(mcount, 255));
      check("idle_last", last0, mlast);
    end
    repeat ($urandom_range(3, 1)) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; mode = 1'b0; limit = 8'hff;
    model_reset();
    do_reset();

    // STEP through 2..11
    for (int i = 0; i < 10; i++) do_edge(1'b0, 255, 1'b0);
    check("step10_cnt", cnt0, 5);
    check("step10_last", last0, 11);

    // SEEK five primes (first one checks the 3-cycle latency)
    do_reset();
    for (int i = 0; i < 5; i++) do_edge(1'b1, 255, 1'b0);
    check("seek5_cnt", cnt0, 5);

    // SEEK with limit 20, then exhausted range
    do_reset();
    for (int i = 0; i < 8; i++) do_edge(1'b1, 20, 1'b0);
    check("seek20_cnt", cnt0, 8);
    check("seek20_last", last0, 19);
    for (int i = 0; i < 3; i++) do_edge(1'b1, 20, 1'b0);
    check("seek20_done", done0, 1);

    // STEP 2..19: the CW=3 instance saturates at 19
    do_reset();
    for (int i = 0; i < 18; i++) do_edge(1'b0, 255, 1'b0);
    check("sat_cnt_cw3", cnt1, 7);
    check("sat_flag_cw3", sat1, 1);

    // Lost tick while testing 9, then the next edge must test 10
    do_reset();
    for (int i = 0; i < 7; i++) do_edge(1'b0, 255, 1'b0);
    do_edge(1'b0, 255, 1'b1);
    do_edge(1'b0, 255, 1'b0);
    do_edge(1'b0, 255, 1'b0);
    check("lost_sticky", lost0, 1);
    check("lost_last", last0, 11);

    // Reset in the middle of a divide (candidate 12)
    @(negedge clk);
    mode = 1'b0; limit = 8'hff; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    check("middiv_busy", busy0, 1);
    do_reset();
    do_edge(1'b0, 255, 1'b0);
    check("after_rst_cnt", cnt0, 1);
    check("after_rst_last", last0, 2);

    // Randomized episodes
    for (int ep = 0; ep < 3; ep++) begin
      do_reset();
      for (int i = 0; i < 25; i++) begin
        int sel, lim;
        sel = $urandom_range(7, 0);
        if (sel == 0)      lim = $urandom_range(255, 0);
        else if (sel < 4)  lim = 255;
        else               lim = $urandom_range(255, (mn > 255) ? 255 : mn);
        do_edge(1'($urandom_range(1, 0)), lim, ($urandom_range(9, 0) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
